// File: rtl/frame_stream_pkg.sv
// Shared state encoding and default parameters for the frame stream reader.
package frame_stream_pkg;

  localparam int DEF_DATAWIDTH      = 16;
  localparam int DEF_ADDRESSWIDTH   = 32;
  localparam int DEF_BYTES_PER_WORD = 2;
  localparam int DEF_FRAMECNTWIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FLUSH     = 3'd4
  } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register for the word stream, carrying frame markers.
// Handshake: a beat transfers on a cycle where st_valid and st_ready are both 1;
// data/sop/eop hold while valid is high and ready is low.
module stream_out_reg #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 sop_in,
  input  logic                 eop_in,
  input  logic                 ready,
  output logic [DATAWIDTH-1:0] data,
  output logic                 valid,
  output logic                 sop,
  output logic                 eop
);

  // The caller only asserts load when the slot is empty or being drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      valid <= 1'b1;
      sop   <= sop_in;
      eop   <= eop_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Drives a read master frame by frame and re-emits the fetched words as a
// framed stream with sop/eop; supports abort with FIFO drain.
module frame_stream_reader
  import frame_stream_pkg::*;
#(
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int FRAMECNTWIDTH  = DEF_FRAMECNTWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESSWIDTH-1:0]  cfg_base,
  input  logic [ADDRESSWIDTH-1:0]  cfg_frame_bytes,
  input  logic [FRAMECNTWIDTH-1:0] cfg_num_frames,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [FRAMECNTWIDTH-1:0] frames_done,
  output logic                     rm_fixed_location,
  output logic [ADDRESSWIDTH-1:0]  rm_read_base,
  output logic [ADDRESSWIDTH-1:0]  rm_read_length,
  output logic                     rm_go,
  input  logic                     rm_done,
  output logic                     rm_read_buffer,
  input  logic [DATAWIDTH-1:0]     rm_buffer_data,
  input  logic                     rm_data_available,
  output logic [DATAWIDTH-1:0]     st_data,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic                     st_sop,
  output logic                     st_eop,
  output state_t                   dbg_state
);

  localparam int SHIFT = $clog2(BYTES_PER_WORD);

  state_t state, state_n;

  logic [ADDRESSWIDTH-1:0]  frame_addr, frame_bytes_q, len_q, words_q, words_left;
  logic [FRAMECNTWIDTH-1:0] num_frames_q;
  logic [1:0]               go_age;

  logic [ADDRESSWIDTH-1:0]  start_words;
  logic                     start_empty, last_frame;
  logic                     load, flush, frame_fin, flush_exit;

  assign start_words       = cfg_frame_bytes >> SHIFT;
  assign start_empty       = (start_words == '0) || (cfg_num_frames == '0);
  assign last_frame        = (frames_done + FRAMECNTWIDTH'(1)) == num_frames_q;
  assign rm_fixed_location = 1'b0;
  assign rm_read_base      = frame_addr;
  assign rm_read_length    = len_q;
  assign busy              = (state != ST_IDLE);
  assign dbg_state         = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    rm_go          = 1'b0;
    rm_read_buffer = 1'b0;
    load           = 1'b0;
    flush          = 1'b0;
    frame_fin      = 1'b0;
    flush_exit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start && !start_empty) state_n = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        rm_go   = 1'b1;
        flush   = cfg_abort;
        state_n = cfg_abort ? ST_FLUSH : ST_STREAM;
      end
      ST_STREAM: begin
        rm_read_buffer = rm_data_available && (words_left != '0) && (!st_valid || st_ready);
        load           = rm_read_buffer;
        flush          = cfg_abort;
        if (cfg_abort)
          state_n = ST_FLUSH;
        else if (load && words_left == ADDRESSWIDTH'(1))
          state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        flush = cfg_abort;
        // Only the eop beat can be pending here, so "slot empty or draining" means it is accepted.
        if (cfg_abort) begin
          state_n = ST_FLUSH;
        end else if (rm_done && (!st_valid || st_ready)) begin
          frame_fin = 1'b1;
          state_n   = last_frame ? ST_IDLE : ST_LAUNCH;
        end
      end
      ST_FLUSH: begin
        rm_read_buffer = rm_data_available;
        if (rm_done && !rm_data_available && go_age != 2'd0) begin
          flush_exit = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_addr    <= '0;
      frame_bytes_q <= '0;
      len_q         <= '0;
      words_q       <= '0;
      words_left    <= '0;
      num_frames_q  <= '0;
      frames_done   <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      go_age        <= 2'd3;
    end else begin
      // go_age == 0 on the first cycle after rm_go; FLUSH may exit from the second.
      if (rm_go)               go_age <= 2'd0;
      else if (go_age != 2'd3) go_age <= go_age + 2'd1;

      if (state == ST_IDLE && cfg_start) begin
        frame_addr    <= cfg_base;
        frame_bytes_q <= cfg_frame_bytes;
        len_q         <= start_words << SHIFT;
        words_q       <= start_words;
        num_frames_q  <= cfg_num_frames;
        frames_done   <= '0;
        done          <= start_empty;
        aborted       <= 1'b0;
      end
      if (state == ST_LAUNCH) words_left <= words_q;
      if (load)               words_left <= words_left - ADDRESSWIDTH'(1);
      if (frame_fin) begin
        frames_done <= frames_done + FRAMECNTWIDTH'(1);
        if (last_frame) done <= 1'b1;
        else            frame_addr <= frame_addr + frame_bytes_q;
      end
      if (flush_exit) begin
        done    <= 1'b1;
        aborted <= 1'b1;
      end
    end
  end

  stream_out_reg #(.DATAWIDTH(DATAWIDTH)) u_out (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .load    (load),
    .data_in (rm_buffer_data),
    .sop_in  (words_left == words_q),
    .eop_in  (words_left == ADDRESSWIDTH'(1)),
    .ready   (st_ready),
    .data    (st_data),
    .valid   (st_valid),
    .sop     (st_sop),
    .eop     (st_eop)
  );

endmodule
